// File: rtl/pcg_health_mon.sv
// Online health monitor for the PCG word stream: repetition-count and windowed monobit tests.
// Monobit accumulation is built only when PCG_HMON_MONOBIT_EN is defined; otherwise windows always pass.
module pcg_health_mon #(
    parameter int unsigned WINDOW     = 512,
    parameter int unsigned RCT_CUTOFF = 3
`ifdef PCG_HMON_MONOBIT_EN
    ,
    parameter int unsigned MONO_LO    = 7800,
    parameter int unsigned MONO_HI    = 8584
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic        healthy,
    output logic        rct_fail,
    output logic        mono_fail,
    output logic [15:0] ones_count,
    output logic        window_done
);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(RCT_CUTOFF);
    localparam logic [10:0] WIN_LAST_IDX = 11'(WINDOW - 1);

    typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_FAIL} state_t;

    state_t         state_reg;
    logic [31:0]    prev_reg;
    logic           prev_ok_reg;
    logic [RW-1:0]  rep_cnt_reg;
    logic [RW-1:0]  rep_cnt_next;
    logic [10:0]    word_cnt_reg;
    logic           accept;
    logic           win_last;
    logic           rct_hit;
    logic           mono_bad;
    logic           any_fail;

    assign accept   = en & data_valid;
    assign win_last = accept && (word_cnt_reg == WIN_LAST_IDX);

    always_comb begin
        rep_cnt_next = RW'(1);
        if (prev_ok_reg && (data_in == prev_reg)) begin
            rep_cnt_next = (rep_cnt_reg == REP_MAX) ? REP_MAX : rep_cnt_reg + RW'(1);
        end
    end

    assign rct_hit  = accept && (rep_cnt_next == REP_MAX);
    assign any_fail = rct_hit | mono_bad;

`ifdef PCG_HMON_MONOBIT_EN
    logic [15:0] acc_reg;
    logic [15:0] ones_count_reg;
    logic        mono_fail_reg;
    logic [5:0]  pop;
    logic [15:0] sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) begin
            pop = pop + {5'd0, data_in[i]};
        end
    end

    // The closing word's popcount belongs to the window it closes.
    assign sum      = acc_reg + {10'd0, pop};
    assign mono_bad = win_last && ((sum < 16'(MONO_LO)) || (sum > 16'(MONO_HI)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg        <= '0;
            ones_count_reg <= '0;
            mono_fail_reg  <= 1'b0;
        end else if (clear) begin
            acc_reg       <= '0;
            mono_fail_reg <= 1'b0;
        end else if (accept) begin
            acc_reg <= win_last ? 16'd0 : sum;
            if (win_last) begin
                ones_count_reg <= sum;
            end
            if (mono_bad) begin
                mono_fail_reg <= 1'b1;
            end
        end
    end

    assign mono_fail  = mono_fail_reg;
    assign ones_count = ones_count_reg;
`else
    assign mono_bad   = 1'b0;
    assign mono_fail  = 1'b0;
    assign ones_count = 16'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_WARMUP;
            prev_reg       <= '0;
            prev_ok_reg    <= 1'b0;
            rep_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            healthy        <= 1'b0;
            rct_fail       <= 1'b0;
            window_done    <= 1'b0;
        end else if (clear) begin
            // A word arriving alongside clear is dropped entirely.
            state_reg      <= ST_WARMUP;
            prev_reg       <= '0;
            prev_ok_reg    <= 1'b0;
            rep_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            data_out_valid <= 1'b0;
            healthy        <= 1'b0;
            rct_fail       <= 1'b0;
            window_done    <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            window_done    <= 1'b0;
            if (accept) begin
                prev_reg     <= data_in;
                prev_ok_reg  <= 1'b1;
                rep_cnt_reg  <= rep_cnt_next;
                word_cnt_reg <= win_last ? 11'd0 : word_cnt_reg + 11'd1;
                window_done  <= win_last;
                if (rct_hit) begin
                    rct_fail <= 1'b1;
                end
                case (state_reg)
                    ST_WARMUP: begin
                        if (any_fail) begin
                            state_reg <= ST_FAIL;
                        end else if (win_last) begin
                            state_reg <= ST_RUN;
                            healthy   <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (any_fail) begin
                            state_reg <= ST_FAIL;
                            healthy   <= 1'b0;
                        end else begin
                            data_out       <= data_in;
                            data_out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_FAIL;
                        healthy   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/pcg_health_mon.md
# pcg_health_mon

Online health monitor on the consumer side of the PCG random stream. It accepts 32-bit words from the generator and runs two checks on them: a word-level repetition-count test (RCT) and a windowed monobit (ones-count) test. Words are forwarded downstream only while the source is judged healthy. It sits between the PCG output and any block that consumes random words.

## Interface
- WINDOW, 512: valid words per monobit window; legal range 2..2047.
- RCT_CUTOFF, 3: number of consecutive identical words that declares an RCT failure; legal range ≥2.
- MONO_LO, 7800: minimum allowed ones count per window, inclusive.
- MONO_HI, 8584: maximum allowed ones count per window, inclusive.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  when low, `data_valid` is ignored and all state holds.
- clear  in  1  one-cycle pulse; leaves FAIL and restarts the warm-up.
- data_in  in  32  random word from the generator.
- data_valid  in  1  `data_in` is valid this cycle.
- data_out  out  32  forwarded word, registered.
- data_out_valid  out  1  `data_out` is valid; asserted only in state RUN.
- healthy  out  1  high in RUN only.
- rct_fail  out  1  sticky; set by a repetition failure.
- mono_fail  out  1  sticky; set by a monobit failure.
- ones_count  out  16  ones total of the last completed window.
- window_done  out  1  one-cycle pulse when a window's result is registered.

## Operation
- A word is accepted in a cycle where `en` = 1 and `data_valid` = 1. Only accepted words affect any state.
- FSM states:
  - WARMUP (entered on reset or `clear`). Moves to RUN at the end of the first window if both tests pass. Moves to FAIL on any failure.
  - RUN. Moves to FAIL on any failure.
  - FAIL. Holds until `clear`.
- RCT:
  - Keep `prev` (32 bits), `prev_ok`, and `rep_cnt`.
  - First accepted word after reset or `clear`: `rep_cnt` = 1, `prev_ok` = 1.
  - Later words: if `data_in` == `prev`, increment `rep_cnt`; otherwise set `rep_cnt` = 1.
  - When `rep_cnt` reaches RCT_CUTOFF: set `rct_fail` and go to FAIL.
  - `rep_cnt` saturates at RCT_CUTOFF.
- Monobit:
  - Add the 6-bit popcount of each accepted word into a 16-bit accumulator.
  - Count words with an 11-bit `word_cnt`.
  - On the WINDOW-th word, the result includes that word's popcount. Compute `sum` = accumulator + popcount.
  - Register `sum` into `ones_count` and pulse `window_done`.
  - If `sum` < MONO_LO or `sum` > MONO_HI: set `mono_fail` and go to FAIL.
  - In the same cycle, clear the accumulator and `word_cnt`; the next accepted word starts a new window.
- Simultaneous events:
  - RCT and monobit failures on the same word set both flags.
  - A failure on the last word of the warm-up window goes to FAIL, not RUN.
- The failing word is never forwarded. Windows keep being counted in FAIL so that `ones_count` stays observable.
- `clear` clears:
  - `rct_fail`, `mono_fail`, `prev_ok`, `rep_cnt`, the accumulator and `word_cnt`.
  - It then enters WARMUP.
- `clear` has priority over an accepted word in the same cycle; that word is discarded.

## Timing
- Reset values:
  - State WARMUP.
  - `data_out` = 0, `data_out_valid` = 0, `healthy` = 0.
  - `rct_fail` = 0, `mono_fail` = 0.
  - `ones_count` = 0, `window_done` = 0.
  - All internal counters 0, `prev_ok` = 0.
- Latency is 1 cycle. A word accepted in cycle N in state RUN, with no failure, appears on `data_out` with `data_out_valid` = 1 in cycle N+1.
- A failure detected on the word accepted in cycle N:
  - Fail flags and the FAIL state are visible in N+1.
  - `healthy` = 0 and `data_out_valid` = 0 in N+1.
- The warm-up window passing on the word in cycle N gives `healthy` = 1 in N+1. Forwarding starts with the next accepted word.
- There is no backpressure: the block accepts one word per cycle.
- `rst` asserted mid-window returns all outputs to their reset values immediately. It is asynchronous.

## Configuration
- `PCG_HMON_MONOBIT_EN` defined: behaviour as specified above.
- `PCG_HMON_MONOBIT_EN` undefined:
  - The accumulator and popcount logic are removed.
  - `mono_fail` and `ones_count` are tied to 0.
  - `word_cnt` and `window_done` remain. Windows always pass, so WARMUP moves to RUN after WINDOW words unless the RCT fails.

## Test plan
- **Reset.** Assert `rst` mid-stream, then release. Every output must be 0 and the state WARMUP. After release, 511 alternating words must leave `healthy` = 0.
- **Warm-up pass.** Feed 512 words alternating 0xAAAAAAAA / 0x55555555. Required:
  - `window_done` pulses and `ones_count` = 8192.
  - `healthy` = 1 one cycle later.
  - The 513th word appears on `data_out` one cycle after it is accepted.
- **RCT failure.** In RUN, feed 0x12345678 three times in a row. Required, one cycle after the third word:
  - `rct_fail` = 1, `healthy` = 0, `data_out_valid` = 0.
  - The first two copies are forwarded; the third is not.
- **Monobit failure.** After reset, feed 512 words alternating 0xFFFFFFFF / 0xFFFFFFFE. Required: `ones_count` = 16128, `mono_fail` = 1, state FAIL, `healthy` never asserted.
- **Clear recovery.** From FAIL, pulse `clear` together with a valid word. Required:
  - Both flags drop to 0 and the discarded word is not counted.
  - After 512 alternating words, `healthy` = 1.
- **Gating.** With `en` = 0, drive 600 valid identical words. Required: no flag changes, no `window_done`, and `word_cnt` is unchanged.
